decoder_round_scheduler: RTL and testbench

Sequences decode rounds through the decoder stage controller. It accepts one round request at a time from the measurement front end with a valid/ready handshake, issues the one-cycle `new_round_start` pulse, and waits for one of three outcomes: a result, a deadlock report, or its own watchdog timeout. It then presents a tagged result record downstream with a valid/ready handshake. Only one round is in flight at a time.

---
 rtl/decoder_round_scheduler.sv | 166 ++++++++++++++++
 tb/tb_decoder_round_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_round_scheduler.sv
// Decode round scheduler: accepts one round request, pulses new_round_start, waits for result/deadlock/watchdog, emits a tagged record.
// Optional statistics counters are built only when DECODER_SCHED_STATS_EN is defined; otherwise the stat_* ports read 0.
module decoder_round_scheduler #(
  parameter int ROUND_ID_WIDTH          = 16,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int TIMEOUT_CYCLES          = 65536,
  parameter int STAT_WIDTH              = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               round_valid,
  output logic                               round_ready,
  input  logic [ROUND_ID_WIDTH-1:0]          round_id,
  output logic                               new_round_start,
  input  logic                               result_valid,
  input  logic                               deadlock,
  input  logic                               final_cardinality,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  input  logic [31:0]                        cycle_counter,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ROUND_ID_WIDTH-1:0]          out_round_id,
  output logic                               out_cardinality,
  output logic [ITERATION_COUNTER_WIDTH-1:0] out_iterations,
  output logic [31:0]                        out_cycles,
  output logic [1:0]                         out_status,
  output logic [STAT_WIDTH-1:0]              stat_rounds,
  output logic [STAT_WIDTH-1:0]              stat_deadlocks,
  output logic [STAT_WIDTH-1:0]              stat_timeouts,
  output logic [STAT_WIDTH-1:0]              stat_max_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_EMIT} state_t;

  localparam int             WDW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  state_t                             r_state;
  state_t                             w_next;
  logic [WDW-1:0]                     r_wd;
  logic [ROUND_ID_WIDTH-1:0]          r_id;
  logic                               r_card;
  logic [ITERATION_COUNTER_WIDTH-1:0] r_iter;
  logic [31:0]                        r_cyc;
  logic [1:0]                         r_status;
  logic                               w_accept;
  logic                               w_exit;
  logic                               w_handshake;
  logic [1:0]                         w_status;

  always_comb begin
    w_next          = r_state;
    round_ready     = 1'b0;
    new_round_start = 1'b0;
    out_valid       = 1'b0;
    w_exit          = 1'b0;
    w_status        = 2'd0;
    unique case (r_state)
      S_IDLE: begin
        round_ready = 1'b1;
        if (round_valid) w_next = S_START;
      end
      S_START: begin
        new_round_start = 1'b1;
        w_next          = S_WAIT;
      end
      S_WAIT: begin
        // result_valid wins over deadlock, which wins over the watchdog
        if (result_valid) begin
          w_exit   = 1'b1;
          w_status = 2'd0;
        end else if (deadlock) begin
          w_exit   = 1'b1;
          w_status = 2'd1;
        end else if (r_wd == WD_LAST) begin
          w_exit   = 1'b1;
          w_status = 2'd2;
        end
        if (w_exit) w_next = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept    = round_valid & round_ready;
  assign w_handshake = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wd     <= '0;
      r_id     <= '0;
      r_card   <= 1'b0;
      r_iter   <= '0;
      r_cyc    <= '0;
      r_status <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_id <= round_id;
        r_wd <= '0;
      end else if (r_state == S_WAIT && !w_exit) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_exit) begin
        r_card   <= (w_status == 2'd0) ? final_cardinality : 1'b0;
        r_iter   <= iteration_counter;
        r_cyc    <= cycle_counter;
        r_status <= w_status;
      end
    end
  end

  assign out_round_id    = r_id;
  assign out_cardinality = r_card;
  assign out_iterations  = r_iter;
  assign out_cycles      = r_cyc;
  assign out_status      = r_status;

`ifdef DECODER_SCHED_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
  localparam int                    CW       = (STAT_WIDTH > 32) ? STAT_WIDTH : 32;

  logic [STAT_WIDTH-1:0] r_rounds;
  logic [STAT_WIDTH-1:0] r_deadlocks;
  logic [STAT_WIDTH-1:0] r_timeouts;
  logic [STAT_WIDTH-1:0] r_max;
  logic [CW-1:0]         w_cyc_ext;
  logic [STAT_WIDTH-1:0] w_cyc_clip;

  // Cycle counts wider than the counter clamp to the saturation value
  assign w_cyc_ext  = CW'(r_cyc);
  assign w_cyc_clip = (w_cyc_ext > CW'(STAT_MAX)) ? STAT_MAX : w_cyc_ext[STAT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rounds    <= '0;
      r_deadlocks <= '0;
      r_timeouts  <= '0;
      r_max       <= '0;
    end else if (w_handshake) begin
      if (r_rounds != STAT_MAX) r_rounds <= r_rounds + 1'b1;
      if (r_status == 2'd1 && r_deadlocks != STAT_MAX) r_deadlocks <= r_deadlocks + 1'b1;
      if (r_status == 2'd2 && r_timeouts != STAT_MAX) r_timeouts <= r_timeouts + 1'b1;
      if (r_status == 2'd0 && w_cyc_clip > r_max) r_max <= w_cyc_clip;
    end
  end

  assign stat_rounds     = r_rounds;
  assign stat_deadlocks  = r_deadlocks;
  assign stat_timeouts   = r_timeouts;
  assign stat_max_cycles = r_max;
`else
  logic w_unused_hs;
  assign w_unused_hs     = w_handshake;
  assign stat_rounds     = '0;
  assign stat_deadlocks  = '0;
  assign stat_timeouts   = '0;
  assign stat_max_cycles = '0;
`endif

endmodule

// File: tb/tb_decoder_round_scheduler.sv
// Directed, table-driven bench for decoder_round_scheduler; the bench drives the stage-controller stub itself.
module tb_decoder_round_scheduler;

  localparam int IDW = 16;
  localparam int ITW = 8;
  localparam int TO  = 128;
  localparam int SW  = 3;
  localparam int SMAX = (1 << SW) - 1;

  localparam int K_OK = 0, K_DL = 1, K_BOTH = 2, K_NONE = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           round_valid;
  logic           round_ready;
  logic [IDW-1:0] round_id;
  logic           new_round_start;
  logic           result_valid;
  logic           deadlock;
  logic           final_cardinality;
  logic [ITW-1:0] iteration_counter;
  logic [31:0]    cycle_counter;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] out_round_id;
  logic           out_cardinality;
  logic [ITW-1:0] out_iterations;
  logic [31:0]    out_cycles;
  logic [1:0]     out_status;
  logic [SW-1:0]  stat_rounds;
  logic [SW-1:0]  stat_deadlocks;
  logic [SW-1:0]  stat_timeouts;
  logic [SW-1:0]  stat_max_cycles;

  decoder_round_scheduler #(
    .ROUND_ID_WIDTH(IDW), .ITERATION_COUNTER_WIDTH(ITW),
    .TIMEOUT_CYCLES(TO), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .round_valid(round_valid), .round_ready(round_ready), .round_id(round_id),
    .new_round_start(new_round_start),
    .result_valid(result_valid), .deadlock(deadlock),
    .final_cardinality(final_cardinality), .iteration_counter(iteration_counter),
    .cycle_counter(cycle_counter),
    .out_valid(out_valid), .out_ready(out_ready), .out_round_id(out_round_id),
    .out_cardinality(out_cardinality), .out_iterations(out_iterations),
    .out_cycles(out_cycles), .out_status(out_status),
    .stat_rounds(stat_rounds), .stat_deadlocks(stat_deadlocks),
    .stat_timeouts(stat_timeouts), .stat_max_cycles(stat_max_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    int             kind;
    int             dly;
    int             bp;
    logic           card;
    logic [ITW-1:0] it;
    logic [31:0]    cyc;
    logic [1:0]     exp_status;
    logic           exp_card;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int m_rounds = 0, m_dl = 0, m_to = 0, m_max = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_record(input string tag, input vec_t v);
    chk({tag, "_id"},     64'(out_round_id),    64'(v.id));
    chk({tag, "_status"}, 64'(out_status),      64'(v.exp_status));
    chk({tag, "_card"},   64'(out_cardinality), 64'(v.exp_card));
    chk({tag, "_iter"},   64'(out_iterations),  64'(v.it));
    chk({tag, "_cyc"},    64'(out_cycles),      64'(v.cyc));
  endtask

  task automatic run_round(input vec_t v);
    int  lat;
    int  pulses;
    int  exp_lat;
    bit  bad;
    int  clip;
    chk("idle_ready", 64'(round_ready), 64'd1);
    round_valid       = 1'b1;
    round_id          = v.id;
    result_valid      = 1'b0;
    deadlock          = 1'b0;
    final_cardinality = v.card;
    iteration_counter = v.it;
    cycle_counter     = v.cyc;
    @(negedge clk);
    round_valid = 1'b0;
    round_id    = 16'hFFFF;
    chk("pulse", 64'(new_round_start), 64'd1);
    chk("start_ready", 64'(round_ready), 64'd0);
    pulses = 1;
    bad    = 1'b0;
    lat    = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (new_round_start) pulses++;
      if (round_ready) bad = 1'b1;
      if (out_valid) break;
      if (lat == v.dly) begin
        if (v.kind == K_OK || v.kind == K_BOTH) result_valid = 1'b1;
        if (v.kind == K_DL || v.kind == K_BOTH) deadlock = 1'b1;
      end
    end
    exp_lat = (v.kind == K_NONE) ? TO + 1 : v.dly + 1;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("wait_ready", 64'(bad), 64'd0);
    check_record("rec", v);
    bad = 1'b0;
    for (int i = 0; i < v.bp; i++) begin
      final_cardinality = ~v.card;
      iteration_counter = ~v.it;
      cycle_counter     = ~v.cyc;
      round_valid       = 1'b1;
      round_id          = 16'h0BAD;
      @(negedge clk);
      if (!out_valid || round_ready || new_round_start || out_round_id != v.id ||
          out_status != v.exp_status || out_cardinality != v.exp_card ||
          out_iterations != v.it || out_cycles != v.cyc) bad = 1'b1;
    end
    if (v.bp > 0) chk("bp_stable", 64'(bad), 64'd0);
    round_valid = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (new_round_start) pulses++;
    chk("done_out_valid", 64'(out_valid), 64'd0);
    chk("done_ready", 64'(round_ready), 64'd1);
    chk("pulse_count", 64'(pulses), 64'd1);
    result_valid = 1'b0;
    deadlock     = 1'b0;
    if (m_rounds < SMAX) m_rounds++;
    if (v.exp_status == 2'd1 && m_dl < SMAX) m_dl++;
    if (v.exp_status == 2'd2 && m_to < SMAX) m_to++;
    clip = (v.cyc > 32'(SMAX)) ? SMAX : int'(v.cyc);
    if (v.exp_status == 2'd0 && clip > m_max) m_max = clip;
  endtask

  task automatic check_stats(input string tag, input int r, input int d, input int t, input int m);
`ifdef DECODER_SCHED_STATS_EN
    chk({tag, "_rounds"},    64'(stat_rounds),     64'(r));
    chk({tag, "_deadlocks"}, 64'(stat_deadlocks),  64'(d));
    chk({tag, "_timeouts"},  64'(stat_timeouts),   64'(t));
    chk({tag, "_max"},       64'(stat_max_cycles), 64'(m));
`else
    chk({tag, "_rounds"},    64'(stat_rounds),     64'd0);
    chk({tag, "_deadlocks"}, 64'(stat_deadlocks),  64'd0);
    chk({tag, "_timeouts"},  64'(stat_timeouts),   64'd0);
    chk({tag, "_max"},       64'(stat_max_cycles), 64'(r + d + t + m) & 64'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench exceeded time limit");
  end

  initial begin
    vec_t tab[9];
    bit   bad;
    tab[0] = '{16'h0005, K_OK,   20, 0,  1'b1, 8'd3,   32'd57,         2'd0, 1'b1};
    tab[1] = '{16'h1234, K_OK,   3,  10, 1'b0, 8'hFF,  32'hDEADBEEF,   2'd0, 1'b0};
    tab[2] = '{16'h0007, K_DL,   100, 0, 1'b1, 8'd9,   32'd200,        2'd1, 1'b0};
    tab[3] = '{16'hABCD, K_BOTH, 1,  2,  1'b1, 8'd4,   32'd5,          2'd0, 1'b1};
    tab[4] = '{16'h0F0F, K_NONE, 0,  1,  1'b1, 8'd2,   32'd77,         2'd2, 1'b0};
    tab[5] = '{16'h0001, K_OK,   1,  0,  1'b1, 8'd1,   32'd1,          2'd0, 1'b1};
    tab[6] = '{16'h0002, K_OK,   2,  0,  1'b0, 8'd2,   32'd2,          2'd0, 1'b0};
    tab[7] = '{16'h0003, K_OK,   5,  0,  1'b1, 8'd3,   32'd3,          2'd0, 1'b1};
    tab[8] = '{16'h0004, K_OK,   1,  0,  1'b1, 8'd4,   32'd4,          2'd0, 1'b1};

    reset = 1'b1; round_valid = 1'b0; round_id = '0; result_valid = 1'b0;
    deadlock = 1'b0; final_cardinality = 1'b0; iteration_counter = '0;
    cycle_counter = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(round_ready), 64'd1);
    chk("rst_pulse", 64'(new_round_start), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", {out_round_id, out_cardinality, out_iterations, out_cycles, out_status}, 64'd0);
    check_stats("rst_stat", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_round(tab[i]);
    check_stats("stat", m_rounds, m_dl, m_to, m_max);

    // Reset while the round sits in WAIT drops it without a record
    round_valid = 1'b1; round_id = 16'h0055;
    @(negedge clk);
    round_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", 64'(round_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_pulse", 64'(new_round_start), 64'd0);
    check_stats("midrst_stat", 0, 0, 0, 0);
    result_valid = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || new_round_start || !round_ready) bad = 1'b1;
    end
    chk("midrst_quiet", 64'(bad), 64'd0);
    result_valid = 1'b0;
    m_rounds = 0; m_dl = 0; m_to = 0; m_max = 0;
    run_round(tab[0]);
    check_stats("post_stat", m_rounds, m_dl, m_to, m_max);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
